ultrasonido_disparo: RTL and testbench
======================================

// Module: ultrasonido_disparo
// PURPOSE
//  Measurement sequencer for the HC-SR04 ultrasonic range path; it sits directly upstream of contador.
//  Issues the sensor TRIGGER pulse and synchronises the raw ECHO input.
//  Drives ENABLE, which gates contador, for exactly the duration of the echo pulse.
//  Flags a missing or overlong echo as TIMEOUT, and repeats every PERIOD_CYCLES while START is held high.
// PARAMETERS
//  TRIG_CYCLES     10     TRIGGER high time in CLKOUT cycles (10 us at 1 MHz)
//  TIMEOUT_CYCLES  30000  max cycles from WAIT_RISE entry to echo fall (both waits combined)
//  PERIOD_CYCLES   60000  cycles from one TRIG entry to the next; must be >= TRIG_CYCLES+TIMEOUT_CYCLES+4
//  CNT_W           16     width of the internal counters; must hold PERIOD_CYCLES
// PORTS
//  CLKOUT   in   1  system clock; all logic on the rising edge
//  reset    in   1  asynchronous, active-low reset
//  START    in   1  level; 1 = run measurements continuously
//  ECHO     in   1  raw sensor echo, asynchronous; synchronised inside this block
//  TRIGGER  out  1  pulse to the sensor trig pin
//  ENABLE   out  1  high while a synchronised echo is in progress; gates contador
//  DONE     out  1  one-cycle strobe at the end of every measurement (valid or timeout)
//  TIMEOUT  out  1  sticky; set when a measurement times out, cleared at the next TRIG entry
//  BUSY     out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (reset=0, async):
//  - FSM=IDLE; all counters=0; sync flops=0.
//  - TRIGGER=ENABLE=DONE=TIMEOUT=BUSY=0.
//  ECHO sync and edges:
//  - Two-flop synchroniser gives echo_s; echo_d is echo_s delayed one cycle.
//  - Rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
//  - Synchronisation adds 2 cycles of latency from ECHO to ENABLE.
//  - All outputs are registered.
//  FSM:
//  - IDLE: if START=1 at a clock edge -> TRIG.
//  - TRIG:
//    - TRIGGER=1 for exactly TRIG_CYCLES cycles.
//    - period_cnt restarts at 0 on entry; TIMEOUT is cleared on entry.
//    - Then -> WAIT_RISE with tmo_cnt=0.
//  - WAIT_RISE:
//    - tmo_cnt increments every cycle.
//    - Rise -> WAIT_FALL; ENABLE=1 on the following cycle.
//    - An echo that is already high on entry is ignored; only a true rise counts.
//  - WAIT_FALL:
//    - ENABLE=1; tmo_cnt keeps counting.
//    - Fall -> HOLDOFF: ENABLE=0 and DONE=1 for one cycle.
//  - Timeout (WAIT_RISE or WAIT_FALL):
//    - Fires when tmo_cnt==TIMEOUT_CYCLES-1.
//    - ENABLE=0, TIMEOUT=1, DONE=1 for one cycle, then -> HOLDOFF.
//    - Timeout takes priority over a fall in the same cycle.
//  - HOLDOFF:
//    - Waits until period_cnt==PERIOD_CYCLES-1.
//    - Then -> TRIG if START=1, else -> IDLE.
//    - Echo edges seen in HOLDOFF are ignored.
//  - period_cnt increments in every state except IDLE. It never wraps because of the PERIOD_CYCLES constraint.
//  - START=0 mid-measurement: the current measurement completes normally; return to IDLE at the end of HOLDOFF.
//  - reset asserted mid-operation: immediate return to reset values; TRIGGER and ENABLE drop asynchronously.
//  - At most one DONE per TRIG. ENABLE and TRIGGER are never high in the same cycle.
// TESTING
//  Params for all tests: TRIG_CYCLES=3, TIMEOUT_CYCLES=20, PERIOD_CYCLES=40.
//  1. Reset: hold reset=0 with START=1 and ECHO=1 -> all outputs 0. Release -> TRIGGER rises 2 cycles later, high exactly 3 cycles.
//  2. Nominal: ECHO high for 8 cycles, starting 4 cycles after TRIGGER falls.
//     -> ENABLE high exactly 8 cycles, lagging ECHO by 2.
//     -> DONE one cycle on ENABLE fall; TIMEOUT=0.
//  3. No echo: ECHO held 0.
//     -> DONE plus TIMEOUT=1, 20 cycles after WAIT_RISE entry.
//     -> Next TRIGGER 40 cycles after the previous one; TIMEOUT clears at that TRIG.
//  4. Stuck echo: ECHO held 1 throughout.
//     -> ENABLE never asserts; timeout as in test 3.
//     -> Long echo (rise, then no fall): ENABLE drops on timeout with TIMEOUT=1.
//  5. Repetition and stop: START=1 -> TRIGGER rising edges every 40 cycles.
//     Drop START mid-WAIT_FALL -> that measurement still ends with DONE; FSM reaches IDLE and BUSY=0.
//  6. Async reset mid-WAIT_FALL -> ENABLE=0 immediately; no DONE; FSM=IDLE.

Source files
------------

// File: rtl/ultrasonido_disparo_if.sv
// Sensor-side signal bundle for the HC-SR04 measurement sequencer.
// The master drives START/ECHO; the slave (sequencer) drives the status outputs.
interface ultrasonido_disparo_if;
    logic START;
    logic ECHO;
    logic TRIGGER;
    logic ENABLE;
    logic DONE;
    logic TIMEOUT;
    logic BUSY;

    modport master (
        output START,
        output ECHO,
        input  TRIGGER,
        input  ENABLE,
        input  DONE,
        input  TIMEOUT,
        input  BUSY
    );

    modport slave (
        input  START,
        input  ECHO,
        output TRIGGER,
        output ENABLE,
        output DONE,
        output TIMEOUT,
        output BUSY
    );
endinterface

// File: rtl/ultrasonido_disparo.sv
// HC-SR04 measurement sequencer: fires TRIGGER, synchronises ECHO, gates contador via ENABLE,
// flags missing/overlong echoes as TIMEOUT and repeats every PERIOD_CYCLES while START is high.
module ultrasonido_disparo #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int PERIOD_CYCLES  = 60000,
    parameter int CNT_W          = 16
) (
    input  logic                  CLKOUT,
    input  logic                  reset,
    ultrasonido_disparo_if.slave  bus,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               echo_meta_q, echo_s_q, echo_d_q;
    logic               trigger_q, enable_q, done_q, timeout_q, busy_q;
    logic               done_d, timeout_d;
    logic               echo_rise, echo_fall, tmo_hit;

    // ECHO is asynchronous to CLKOUT: two flops for metastability, a third for edge detection.
    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_d_q    <= 1'b0;
        end else begin
            echo_meta_q <= bus.ECHO;
            echo_s_q    <= echo_meta_q;
            echo_d_q    <= echo_s_q;
        end
    end

    assign echo_rise = echo_s_q & ~echo_d_q;
    assign echo_fall = ~echo_s_q & echo_d_q;
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START) state_d = S_TRIG;
            end
            S_TRIG: begin
                timeout_d = 1'b0;
                if (period_cnt_q == TRIG_LAST) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (tmo_hit) begin
                    state_d   = S_HOLDOFF;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (echo_rise) begin
                    state_d = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                // A timeout wins over a fall seen in the same cycle.
                if (tmo_hit) begin
                    state_d   = S_HOLDOFF;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (echo_fall) begin
                    state_d = S_HOLDOFF;
                    done_d  = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (period_cnt_q == PERIOD_LAST) state_d = bus.START ? S_TRIG : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        period_cnt_d = '0;
        if (state_d == S_TRIG && state_q != S_TRIG) begin
            period_cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            period_cnt_d = period_cnt_q + CNT_W'(1);
        end
        tmo_cnt_d = '0;
        if (state_q == S_WAIT_RISE || state_q == S_WAIT_FALL) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLKOUT or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            trigger_q    <= 1'b0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            // TRIGGER trails the TRIG state by one cycle, so it can never overlap ENABLE.
            trigger_q    <= (state_q == S_TRIG);
            enable_q     <= (state_d == S_WAIT_FALL);
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign bus.TRIGGER = trigger_q;
    assign bus.ENABLE  = enable_q;
    assign bus.DONE    = done_q;
    assign bus.TIMEOUT = timeout_q;
    assign bus.BUSY    = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ultrasonido_disparo.sv
// Directed bench for ultrasonido_disparo with TRIG=3, TIMEOUT=20, PERIOD=40.
// Cycle k is observed at the falling edge following the k-th rising edge after reset release.
module tb_ultrasonido_disparo;

    localparam logic [31:0] ST_IDLE      = 32'd0;
    localparam logic [31:0] ST_TRIG      = 32'd1;
    localparam logic [31:0] ST_WAIT_RISE = 32'd2;
    localparam logic [31:0] ST_WAIT_FALL = 32'd3;
    localparam logic [31:0] ST_HOLDOFF   = 32'd4;

    logic       CLKOUT = 1'b0;
    logic       reset;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    always #5 CLKOUT = ~CLKOUT;

    ultrasonido_disparo_if bus ();

    ultrasonido_disparo #(
        .TRIG_CYCLES    (3),
        .TIMEOUT_CYCLES (20),
        .PERIOD_CYCLES  (40),
        .CNT_W          (16)
    ) dut (
        .CLKOUT  (CLKOUT),
        .reset   (reset),
        .bus     (bus),
        .state_o (state)
    );

    task automatic tick();
        @(negedge CLKOUT);
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with START and ECHO high.
        reset     = 1'b0;
        bus.START = 1'b1;
        bus.ECHO  = 1'b1;
        repeat (3) @(negedge CLKOUT);
        check("rst_trigger", 32'(bus.TRIGGER), 32'd0);
        check("rst_enable",  32'(bus.ENABLE),  32'd0);
        check("rst_done",    32'(bus.DONE),    32'd0);
        check("rst_timeout", 32'(bus.TIMEOUT), 32'd0);
        check("rst_busy",    32'(bus.BUSY),    32'd0);
        check("rst_state",   32'(state),       ST_IDLE);

        reset    = 1'b1;
        bus.ECHO = 1'b0;
        cyc      = 0;
        tick();
        check("rel_state", 32'(state), ST_TRIG);
        check("rel_busy",  32'(bus.BUSY), 32'd1);
        check("rel_trig1", 32'(bus.TRIGGER), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("trig_width", 32'(bus.TRIGGER), 32'(cyc <= 4));
        end
        check("wr_state", 32'(state), ST_WAIT_RISE);

        // Nominal echo: 8 cycles high, raised 4 cycles after TRIGGER falls.
        go_to(8);
        bus.ECHO = 1'b1;
        for (int k = 9; k <= 20; k++) begin
            tick();
            check("nom_enable", 32'(bus.ENABLE), 32'(cyc >= 11 && cyc <= 18));
            check("nom_done",   32'(bus.DONE),   32'(cyc == 19));
            check("nom_tmo",    32'(bus.TIMEOUT), 32'd0);
            if (cyc == 16) bus.ECHO = 1'b0;
        end
        go_to(41);
        check("per2_state", 32'(state), ST_TRIG);
        check("per2_trig0", 32'(bus.TRIGGER), 32'd0);
        tick();
        check("per2_trig1", 32'(bus.TRIGGER), 32'd1);

        // No echo: timeout 20 cycles after WAIT_RISE entry at cycle 44.
        go_to(63);
        check("noecho_done_pre", 32'(bus.DONE), 32'd0);
        check("noecho_tmo_pre",  32'(bus.TIMEOUT), 32'd0);
        tick();
        check("noecho_done",  32'(bus.DONE), 32'd1);
        check("noecho_tmo",   32'(bus.TIMEOUT), 32'd1);
        check("noecho_state", 32'(state), ST_HOLDOFF);
        tick();
        check("noecho_done_once", 32'(bus.DONE), 32'd0);
        check("noecho_sticky",    32'(bus.TIMEOUT), 32'd1);

        // Stuck-high echo: raised during HOLDOFF, never produces a rise in WAIT_RISE.
        go_to(70);
        bus.ECHO = 1'b1;
        go_to(81);
        check("per3_tmo_hold", 32'(bus.TIMEOUT), 32'd1);
        check("per3_trig0",    32'(bus.TRIGGER), 32'd0);
        tick();
        check("per3_tmo_clr", 32'(bus.TIMEOUT), 32'd0);
        check("per3_trig1",   32'(bus.TRIGGER), 32'd1);
        for (int k = 83; k <= 103; k++) begin
            tick();
            check("stuck_enable", 32'(bus.ENABLE), 32'd0);
            check("stuck_done",   32'(bus.DONE), 32'd0);
        end
        tick();
        check("stuck_done_end", 32'(bus.DONE), 32'd1);
        check("stuck_tmo",      32'(bus.TIMEOUT), 32'd1);
        check("stuck_enable_end", 32'(bus.ENABLE), 32'd0);

        // Long echo: rise at cycle 128, no fall, ENABLE dropped by the timeout.
        go_to(110);
        bus.ECHO = 1'b0;
        go_to(121);
        check("per4_state", 32'(state), ST_TRIG);
        go_to(126);
        bus.ECHO = 1'b1;
        go_to(128);
        check("long_enable_pre", 32'(bus.ENABLE), 32'd0);
        tick();
        check("long_enable", 32'(bus.ENABLE), 32'd1);
        check("long_state",  32'(state), ST_WAIT_FALL);
        go_to(143);
        check("long_enable_hold", 32'(bus.ENABLE), 32'd1);
        check("long_tmo_pre",     32'(bus.TIMEOUT), 32'd0);
        check("long_done_pre",    32'(bus.DONE), 32'd0);
        tick();
        check("long_enable_drop", 32'(bus.ENABLE), 32'd0);
        check("long_done",        32'(bus.DONE), 32'd1);
        check("long_tmo",         32'(bus.TIMEOUT), 32'd1);

        // Repetition then stop: START dropped during WAIT_FALL.
        go_to(150);
        bus.ECHO = 1'b0;
        go_to(161);
        check("per5_trig0", 32'(bus.TRIGGER), 32'd0);
        tick();
        check("per5_trig1", 32'(bus.TRIGGER), 32'd1);
        go_to(166);
        bus.ECHO = 1'b1;
        go_to(169);
        check("stop_enable", 32'(bus.ENABLE), 32'd1);
        go_to(172);
        bus.START = 1'b0;
        go_to(174);
        bus.ECHO = 1'b0;
        go_to(176);
        check("stop_enable_hold", 32'(bus.ENABLE), 32'd1);
        check("stop_done_pre",    32'(bus.DONE), 32'd0);
        tick();
        check("stop_enable_drop", 32'(bus.ENABLE), 32'd0);
        check("stop_done",        32'(bus.DONE), 32'd1);
        check("stop_tmo",         32'(bus.TIMEOUT), 32'd0);
        check("stop_state",       32'(state), ST_HOLDOFF);
        go_to(200);
        check("stop_busy_hold", 32'(bus.BUSY), 32'd1);
        tick();
        check("stop_busy",  32'(bus.BUSY), 32'd0);
        check("stop_state_idle", 32'(state), ST_IDLE);
        go_to(204);
        check("idle_trig", 32'(bus.TRIGGER), 32'd0);
        check("idle_state", 32'(state), ST_IDLE);

        // Restart, then async reset in WAIT_FALL.
        go_to(205);
        bus.START = 1'b1;
        tick();
        check("restart_state", 32'(state), ST_TRIG);
        go_to(211);
        bus.ECHO = 1'b1;
        go_to(214);
        check("ar_enable_pre", 32'(bus.ENABLE), 32'd1);
        check("ar_state_pre",  32'(state), ST_WAIT_FALL);
        go_to(216);
        reset = 1'b0;
        #1;
        check("ar_enable", 32'(bus.ENABLE), 32'd0);
        check("ar_state",  32'(state), ST_IDLE);
        check("ar_busy",   32'(bus.BUSY), 32'd0);
        check("ar_done",   32'(bus.DONE), 32'd0);
        check("ar_trig",   32'(bus.TRIGGER), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ar_done_hold",   32'(bus.DONE), 32'd0);
            check("ar_enable_hold", 32'(bus.ENABLE), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
